// File: rtl/instr_cache_assoc_if.sv
// Fetch/refill bus of the associative instruction cache.
// master: fetch stage + instruction memory side; slave: the cache.
interface instr_cache_assoc_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_BITS = 128
);
    localparam int unsigned OFFSET_W = $clog2(LINE_BITS / 8);

    logic                       flush;
    logic                       mem_read;
    logic [ADDR_W-1:0]          address;
    logic [31:0]                readdata;
    logic                       cache_hit;
    logic                       busy;
    logic                       mem_req;
    logic [ADDR_W-OFFSET_W-1:0] mem_req_addr;
    logic [LINE_BITS-1:0]       mem_rdata;
    logic                       mem_rvalid;

    modport master (
        output flush, mem_read, address, mem_rdata, mem_rvalid,
        input  readdata, cache_hit, busy, mem_req, mem_req_addr
    );

    modport slave (
        input  flush, mem_read, address, mem_rdata, mem_rvalid,
        output readdata, cache_hit, busy, mem_req, mem_req_addr
    );
endinterface

// File: rtl/instr_cache_assoc.sv
// Parametrised 1/2-way instruction cache with LRU replacement, miss FSM,
// critical-word forwarding and flush-safe refill draining.
// Optional macro ICACHE_PERF_EN adds hit_count/miss_count lookup counters.
module instr_cache_assoc #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_SETS  = 4,
    parameter int unsigned LINE_BITS = 128,
    parameter int unsigned WAYS      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    instr_cache_assoc_if.slave        bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);
    localparam int unsigned OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int unsigned INDEX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WORD_W   = OFFSET_W - 2;
    localparam int unsigned WAY_W    = 1;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

    state_t                           state;
    logic [NUM_SETS-1:0][WAYS-1:0]    valid_q;
    logic [NUM_SETS-1:0]              lru_q;
    logic [TAG_W-1:0]                 tag_q  [WAYS][NUM_SETS];
    logic [LINE_BITS-1:0]             data_q [WAYS][NUM_SETS];

    logic [31:0]                      readdata_q;
    logic                             cache_hit_q;
    logic                             mem_req_q;
    logic [ADDR_W-OFFSET_W-1:0]       mem_req_addr_q;

    logic [TAG_W-1:0]                 miss_tag_q;
    logic [INDEX_W-1:0]               miss_idx_q;
    logic [WORD_W-1:0]                miss_word_q;
    logic [WAY_W-1:0]                 miss_way_q;

    logic [TAG_W-1:0]                 tag_c;
    logic [INDEX_W-1:0]               idx_c;
    logic [WORD_W-1:0]                word_c;
    logic                             hit_c;
    logic [WAY_W-1:0]                 hit_way_c;
    logic [WAY_W-1:0]                 victim_c;
    logic                             unused_addr_bits;

    assign tag_c            = bus.address[ADDR_W-1 -: TAG_W];
    assign idx_c            = bus.address[OFFSET_W +: INDEX_W];
    assign word_c           = bus.address[2 +: WORD_W];
    assign unused_addr_bits = ^bus.address[1:0];

    assign bus.readdata     = readdata_q;
    assign bus.cache_hit    = cache_hit_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_req_addr = mem_req_addr_q;
    assign bus.busy         = (state != IDLE);

    function automatic logic [31:0] pick_word(input logic [LINE_BITS-1:0] line,
                                              input logic [WORD_W-1:0]    w);
        return line[{w, 5'b0} +: 32];
    endfunction

    // Tag compare across ways and victim choice (first invalid way, else LRU).
    always_comb begin
        logic found;
        hit_c     = 1'b0;
        hit_way_c = '0;
        found     = 1'b0;
        victim_c  = lru_q[idx_c];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_c][w] && (tag_q[w][idx_c] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!found && !valid_q[idx_c][w]) begin
                victim_c = WAY_W'(w);
                found    = 1'b1;
            end
        end
        if (WAYS == 1) begin
            victim_c = '0;
        end
    end

    // Miss FSM, array updates and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            valid_q        <= '0;
            lru_q          <= '0;
            readdata_q     <= '0;
            cache_hit_q    <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_req_addr_q <= '0;
            miss_tag_q     <= '0;
            miss_idx_q     <= '0;
            miss_word_q    <= '0;
            miss_way_q     <= '0;
`ifdef ICACHE_PERF_EN
            hit_count      <= '0;
            miss_count     <= '0;
`endif
        end else begin
            cache_hit_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end else if (bus.mem_read) begin
                        if (hit_c) begin
                            readdata_q  <= pick_word(data_q[hit_way_c][idx_c], word_c);
                            cache_hit_q <= 1'b1;
                            if (WAYS > 1) begin
                                lru_q[idx_c] <= ~hit_way_c;
                            end
`ifdef ICACHE_PERF_EN
                            hit_count <= hit_count + 32'd1;
`endif
                        end else begin
                            miss_tag_q     <= tag_c;
                            miss_idx_q     <= idx_c;
                            miss_word_q    <= word_c;
                            miss_way_q     <= victim_c;
                            mem_req_q      <= 1'b1;
                            mem_req_addr_q <= bus.address[ADDR_W-1:OFFSET_W];
                            state          <= MISS;
`ifdef ICACHE_PERF_EN
                            miss_count <= miss_count + 32'd1;
`endif
                        end
                    end
                end
                MISS: begin
                    if (bus.mem_rvalid) begin
                        mem_req_q <= 1'b0;
                        state     <= IDLE;
                        if (bus.flush) begin
                            valid_q <= '0;
                        end else begin
                            data_q[miss_way_q][miss_idx_q]  <= bus.mem_rdata;
                            tag_q[miss_way_q][miss_idx_q]   <= miss_tag_q;
                            valid_q[miss_idx_q][miss_way_q] <= 1'b1;
                            if (WAYS > 1) begin
                                lru_q[miss_idx_q] <= ~miss_way_q;
                            end
                            readdata_q  <= pick_word(bus.mem_rdata, miss_word_q);
                            cache_hit_q <= 1'b1;
                        end
                    end else if (bus.flush) begin
                        valid_q <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end
                    if (bus.mem_rvalid) begin
                        mem_req_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_cache_assoc.sv
// Scoreboard bench for instr_cache_assoc (4 sets, 128-bit lines, 2 ways).
module tb_instr_cache_assoc;
    logic clk = 1'b0;
    logic reset = 1'b0;

    instr_cache_assoc_if #(.ADDR_W(32), .LINE_BITS(128)) bus();

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instr_cache_assoc #(
        .ADDR_W(32), .NUM_SETS(4), .LINE_BITS(128), .WAYS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] hit_q[$];
    logic [31:0] req_q[$];
    logic        req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word w of the line at line address la is C0DE0000 | la<<4 | w.
    function automatic logic [127:0] pat_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*32 +: 32] = 32'hC0DE_0000 | (32'(la) << 4) | 32'(w);
        end
        return l;
    endfunction

    // Monitor: each hit pulse and each rising mem_req must match the scoreboard.
    always @(negedge clk) begin
        if (bus.cache_hit) begin
            if (hit_q.size() == 0) check("unexpected_hit", 32'(bus.cache_hit), 32'd0);
            else check("hit_data", bus.readdata, hit_q.pop_front());
        end
        if (bus.mem_req && !req_prev) begin
            if (req_q.size() == 0) check("unexpected_req", 32'(bus.mem_req), 32'd0);
            else check("req_addr", 32'(bus.mem_req_addr), req_q.pop_front());
        end
        req_prev = bus.mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_hit", 32'(bus.cache_hit), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr, input bit hit, input logic [31:0] exp);
        bus.address  = addr;
        bus.mem_read = 1'b1;
        if (hit) hit_q.push_back(exp);
        else req_q.push_back(exp);
        tick();
        bus.mem_read = 1'b0;
        check(hit ? "busy_after_hit" : "busy_after_miss", 32'(bus.busy), hit ? 32'd0 : 32'd1);
    endtask

    task automatic refill(input logic [127:0] line, input logic [31:0] exp);
        int n = 0;
        while (!bus.mem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", 32'(bus.mem_req), 32'd1);
        bus.mem_rdata  = line;
        bus.mem_rvalid = 1'b1;
        hit_q.push_back(exp);
        tick();
        bus.mem_rvalid = 1'b0;
        check("busy_after_refill", 32'(bus.busy), 32'd0);
        check("req_after_refill", 32'(bus.mem_req), 32'd0);
    endtask

    task automatic flush_pulse();
        bus.flush    = 1'b1;
        bus.mem_read = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.mem_read = 1'b0;
        check("flush_nohit", 32'(bus.cache_hit), 32'd0);
        check("flush_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0; bus.mem_read = 1'b0; bus.address = '0;
        bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        tick(); tick();
        do_reset();

        // 1: forwarded critical word, then a hit on another word of the line
        fetch(32'h40, 1'b0, 32'h4);
        check("t1_req_level", 32'(bus.mem_req), 32'd1);
        refill({32'h44, 32'h33, 32'h22, 32'h11}, 32'h11);
        fetch(32'h48, 1'b1, 32'h33);

        // 2: two-way fill of set 0 and LRU eviction order
        do_reset();
        fetch(32'h000, 1'b0, 32'h0);  refill(pat_line(28'h0), 32'hC0DE_0000);
        fetch(32'h040, 1'b0, 32'h4);  refill(pat_line(28'h4), 32'hC0DE_0040);
        fetch(32'h008, 1'b1, 32'hC0DE_0002);
        fetch(32'h080, 1'b0, 32'h8);  refill(pat_line(28'h8), 32'hC0DE_0080);
        fetch(32'h000, 1'b1, 32'hC0DE_0000);
        fetch(32'h084, 1'b1, 32'hC0DE_0081);
        fetch(32'h040, 1'b0, 32'h4);  refill(pat_line(28'h4), 32'hC0DE_0040);
        fetch(32'h080, 1'b1, 32'hC0DE_0080);
        fetch(32'h000, 1'b0, 32'h0);  refill(pat_line(28'h0), 32'hC0DE_0000);

        // 3: flush in IDLE wins over a lookup and invalidates the line
        do_reset();
        fetch(32'h100, 1'b0, 32'h10); refill(pat_line(28'h10), 32'hC0DE_0100);
        fetch(32'h10C, 1'b1, 32'hC0DE_0103);
        flush_pulse();
        fetch(32'h100, 1'b0, 32'h10); refill(pat_line(28'h10), 32'hC0DE_0100);

        // 4: flush during refill drains it; flush coincident with rvalid drops the line
        fetch(32'h200, 1'b0, 32'h20);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("drain_busy", 32'(bus.busy), 32'd1);
        check("drain_req", 32'(bus.mem_req), 32'd1);
        tick(); tick();
        bus.mem_rdata = pat_line(28'h20); bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        check("drain_done_busy", 32'(bus.busy), 32'd0);
        check("drain_done_req", 32'(bus.mem_req), 32'd0);
        fetch(32'h200, 1'b0, 32'h20); refill(pat_line(28'h20), 32'hC0DE_0200);
        fetch(32'h240, 1'b0, 32'h24);
        bus.flush = 1'b1; bus.mem_rdata = pat_line(28'h24); bus.mem_rvalid = 1'b1;
        tick();
        bus.flush = 1'b0; bus.mem_rvalid = 1'b0;
        check("coinc_busy", 32'(bus.busy), 32'd0);
        check("coinc_req", 32'(bus.mem_req), 32'd0);
        fetch(32'h240, 1'b0, 32'h24); refill(pat_line(28'h24), 32'hC0DE_0240);
        fetch(32'h200, 1'b0, 32'h20); refill(pat_line(28'h20), 32'hC0DE_0200);

        // 5: reset abandons an in-flight miss; late rvalid ignored
        fetch(32'h300, 1'b0, 32'h30);
        do_reset();
        bus.mem_rdata = pat_line(28'h30); bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        check("late_rvalid_busy", 32'(bus.busy), 32'd0);
        check("late_rvalid_readdata", bus.readdata, 32'd0);
        fetch(32'h300, 1'b0, 32'h30); refill(pat_line(28'h30), 32'hC0DE_0300);

`ifdef ICACHE_PERF_EN
        // 6: lookup counters survive flush
        do_reset();
        check("perf_rst_hits", hit_count, 32'd0);
        check("perf_rst_miss", miss_count, 32'd0);
        fetch(32'h000, 1'b0, 32'h0);  refill(pat_line(28'h0), 32'hC0DE_0000);
        fetch(32'h040, 1'b0, 32'h4);  refill(pat_line(28'h4), 32'hC0DE_0040);
        fetch(32'h004, 1'b1, 32'hC0DE_0001);
        fetch(32'h044, 1'b1, 32'hC0DE_0041);
        fetch(32'h008, 1'b1, 32'hC0DE_0002);
        check("perf_hits", hit_count, 32'd3);
        check("perf_miss", miss_count, 32'd2);
        flush_pulse();
        check("perf_hits_flush", hit_count, 32'd3);
        check("perf_miss_flush", miss_count, 32'd2);
`endif

        tick(); tick();
        check("hit_q_empty", 32'(hit_q.size()), 32'd0);
        check("req_q_empty", 32'(req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
